// File: rtl/mux_rr_n.sv
// N:1 valid/ready merge with a registered output stage.
// An internal round-robin or fixed-priority arbiter picks the channel.
module mux_rr_n #(
  parameter int unsigned N    = 4,
  parameter int unsigned W    = 8,
  parameter int unsigned MODE = 0,
  localparam int unsigned SW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N*W-1:0]    in_data,
  input  logic [N-1:0]      in_valid,
  output logic [N-1:0]      in_ready,
  output logic [W-1:0]      out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SW-1:0]     out_sel
);

  logic [W-1:0]  out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic [SW-1:0] out_sel_q, out_sel_d;
  logic [SW-1:0] ptr_q, ptr_d;

  logic          has_grant;
  logic [SW-1:0] grant;
  logic [SW:0]   rr_idx;
  logic [W-1:0]  grant_data;
  logic          load;
  logic          xfer;

  // Arbiter: scan downward so the first candidate in scan order is the last one written.
  always_comb begin
    has_grant = 1'b0;
    grant     = '0;
    rr_idx    = '0;
    if (MODE == 0) begin
      for (int k = int'(N) - 1; k >= 0; k--) begin
        rr_idx = {1'b0, ptr_q} + (SW+1)'(k);
        if (rr_idx >= (SW+1)'(N)) begin
          rr_idx = rr_idx - (SW+1)'(N);
        end
        if (in_valid[SW'(rr_idx)]) begin
          has_grant = 1'b1;
          grant     = SW'(rr_idx);
        end
      end
    end else begin
      for (int k = int'(N) - 1; k >= 0; k--) begin
        if (in_valid[k]) begin
          has_grant = 1'b1;
          grant     = SW'(k);
        end
      end
    end
  end

  // Handshake and next-state for the output register and pointer.
  always_comb begin
    grant_data  = '0;
    in_ready    = '0;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;

    load = !out_valid_q || out_ready;
    xfer = has_grant && load && !rst;

    for (int i = 0; i < int'(N); i++) begin
      if (grant == SW'(i)) begin
        grant_data = in_data[i*W +: W];
      end
      in_ready[i] = xfer && (grant == SW'(i));
    end

    if (xfer) begin
      out_data_d  = grant_data;
      out_sel_d   = grant;
      out_valid_d = 1'b1;
      if (MODE == 0) begin
        // Explicit compare keeps the wrap correct for non-power-of-two N.
        ptr_d = (grant == SW'(N - 1)) ? '0 : grant + SW'(1);
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_sel   = out_sel_q;

endmodule
